// File: rtl/debug_access_ctrl_pkg.sv
// Shared encodings for the debug access controller: lock states, debug
// command codes and the default unlock key.
package debug_access_ctrl_pkg;

    typedef enum logic [1:0] {
        LS_LOCKED   = 2'b00,
        LS_UNLOCKED = 2'b01,
        LS_LOCKOUT  = 2'b10
    } lock_state_e;

    typedef enum logic [1:0] {
        CMD_READ   = 2'b00,
        CMD_UNLOCK = 2'b01,
        CMD_RELOCK = 2'b10,
        CMD_RSVD   = 2'b11
    } dbg_cmd_e;

    localparam logic [31:0] DEFAULT_UNLOCK_KEY = 32'hA5C3_0F1E;

endpackage

// File: rtl/debug_access_ctrl_arb.sv
// Two-requester round-robin arbiter for the shared register port.
// Requester 0 is the functional writer, requester 1 is the debug port.
// The pointer names the side that wins the next contended cycle and
// flips only when both sides actually competed.
module dac_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // A requester wins if it is alone, or if the pointer favours it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        assign gnt[gi] = req[gi] & (~req[1-gi] | (ptr_q == 1'(gi)));
    end

    // Hand priority to the other side after every contended grant.
    always_comb begin
        ptr_d = ptr_q;
        if (req == 2'b11) begin
            ptr_d = ~ptr_q;
        end
    end

    // Pointer register; starts favouring the functional side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/debug_access_ctrl.sv
// Access controller for the shared data register. Functional writes are
// always allowed; debug reads are only answered with data while a
// key-unlocked session is open. Repeated bad keys force a timed lockout.
module debug_access_ctrl
    import debug_access_ctrl_pkg::*;
#(
    parameter int              DW             = 32,
    parameter logic [DW-1:0]   UNLOCK_KEY     = DW'(DEFAULT_UNLOCK_KEY),
    parameter int              MAX_FAIL       = 3,
    parameter int              SESSION_CYCLES = 1024,
    parameter int              LOCKOUT_CYCLES = 4096,
    parameter int              TW             = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          func_valid,
    input  logic [DW-1:0] func_data,
    output logic          func_ready,
    input  logic          dbg_req,
    input  logic [1:0]    dbg_cmd,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_err,
    output logic [DW-1:0] data_out,
    output logic [1:0]    lock_state
);

    localparam int            FW             = $clog2(MAX_FAIL + 1);
    localparam logic [FW-1:0] FAIL_LAST      = FW'(MAX_FAIL - 1);
    localparam logic [TW-1:0] SESSION_RELOAD = TW'(SESSION_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_RELOAD = TW'(LOCKOUT_CYCLES - 1);

    lock_state_e   state_q, state_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] data_q, data_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [1:0]    gnt;
    logic          func_gnt;
    logic          dbg_gnt;
    dbg_cmd_e      cmd;

    assign cmd = dbg_cmd_e'(dbg_cmd);

    // A debug request is masked during its own ack cycle so that a held
    // dbg_req cannot be granted twice for one command.
    dac_rr_arbiter u_arb (
        .clk (clk),
        .rst (rst),
        .req ({dbg_req & ~ack_q, func_valid}),
        .gnt (gnt)
    );

    assign func_gnt   = gnt[0];
    assign dbg_gnt    = gnt[1];
    assign func_ready = func_gnt;

    assign dbg_ack    = ack_q;
    assign dbg_rdata  = rdata_q;
    assign dbg_err    = err_q;
    assign data_out   = data_q;
    assign lock_state = state_q;

    // Lock FSM, session/lockout timer, fail counter and register update.
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;

        if (func_gnt) begin
            data_d = func_data;
        end

        // Background countdown; a debug grant in a session overrides it below.
        case (state_q)
            LS_UNLOCKED: begin
                if (!dbg_gnt) begin
                    if (timer_q == '0) begin
                        state_d = LS_LOCKED;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            LS_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = LS_LOCKED;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: ;
        endcase

        if (dbg_gnt) begin
            ack_d = 1'b1;
            case (cmd)
                CMD_READ: begin
                    if (state_q == LS_UNLOCKED) begin
                        rdata_d = data_q;
                        timer_d = SESSION_RELOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_UNLOCK: begin
                    case (state_q)
                        LS_LOCKED: begin
                            if (dbg_wdata == UNLOCK_KEY) begin
                                state_d = LS_UNLOCKED;
                                fail_d  = '0;
                                timer_d = SESSION_RELOAD;
                            end else begin
                                err_d = 1'b1;
                                if (fail_q == FAIL_LAST) begin
                                    state_d = LS_LOCKOUT;
                                    timer_d = LOCKOUT_RELOAD;
                                    fail_d  = '0;
                                end else begin
                                    fail_d = fail_q + 1'b1;
                                end
                            end
                        end
                        LS_UNLOCKED: begin
                            timer_d = SESSION_RELOAD;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
                CMD_RELOCK: begin
                    if (state_q == LS_LOCKOUT) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LS_LOCKED;
                        timer_d = '0;
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LS_LOCKED;
            fail_q  <= '0;
            timer_q <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_debug_access_ctrl.sv
// Bench for debug_access_ctrl: debug responses are predicted into a queue
// when a command is driven and compared when dbg_ack shows up.
module tb_debug_access_ctrl;
    import debug_access_ctrl_pkg::*;

    localparam logic [31:0] KEY = 32'hA5C3_0F1E;

    logic        clk;
    logic        rst;
    logic        func_valid;
    logic [31:0] func_data;
    logic        func_ready;
    logic        dbg_req;
    logic [1:0]  dbg_cmd;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_err;
    logic [31:0] data_out;
    logic [1:0]  lock_state;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    lock_state_e model_state = LS_LOCKED;
    int          model_fail  = 0;
    logic [31:0] model_reg   = '0;

    debug_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .func_valid (func_valid),
        .func_data  (func_data),
        .func_ready (func_ready),
        .dbg_req    (dbg_req),
        .dbg_cmd    (dbg_cmd),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .dbg_err    (dbg_err),
        .data_out   (data_out),
        .lock_state (lock_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Response monitor: every ack must match the oldest prediction.
    always @(negedge clk) begin
        if (dbg_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("ack_unexpected", 32'(dbg_ack), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn t=%0t rdata=%h err=%b exp_rdata=%h exp_err=%b",
                         $time, dbg_rdata, dbg_err, mon_e.rdata, mon_e.err);
                check_val("dbg_rdata", dbg_rdata, mon_e.rdata);
                check_val("dbg_err", 32'(dbg_err), 32'(mon_e.err));
            end
        end else begin
            check_val("rdata_idle", dbg_rdata, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    // Issue one debug command (granted in the current cycle, debug side
    // uncontended), predict its response, and return two cycles later.
    task automatic dbg_txn(input dbg_cmd_e cmd, input logic [31:0] key, output int gcyc);
        exp_t e;
        dbg_req   = 1'b1;
        dbg_cmd   = cmd;
        dbg_wdata = key;
        gcyc      = cyc;
        e.rdata   = '0;
        e.err     = 1'b1;
        case (cmd)
            CMD_READ: begin
                if (model_state == LS_UNLOCKED) begin
                    e.rdata = model_reg;
                    e.err   = 1'b0;
                end
            end
            CMD_UNLOCK: begin
                if (model_state == LS_UNLOCKED) begin
                    e.err = 1'b0;
                end else if (model_state == LS_LOCKED) begin
                    if (key == KEY) begin
                        e.err       = 1'b0;
                        model_state = LS_UNLOCKED;
                        model_fail  = 0;
                    end else begin
                        model_fail++;
                        if (model_fail == 3) begin
                            model_state = LS_LOCKOUT;
                            model_fail  = 0;
                        end
                    end
                end
            end
            CMD_RELOCK: begin
                if (model_state != LS_LOCKOUT) begin
                    e.err       = 1'b0;
                    model_state = LS_LOCKED;
                end
            end
            default: ;
        endcase
        exp_q.push_back(e);
        step();
        dbg_req = 1'b0;
        step();
        check_val("lock_state", 32'(lock_state), 32'(model_state));
    endtask

    task automatic func_write(input logic [31:0] d);
        func_valid = 1'b1;
        func_data  = d;
        @(negedge clk);
        check_val("func_ready_solo", 32'(func_ready), 32'd1);
        step();
        func_valid = 1'b0;
        model_reg  = d;
        check_val("data_out", data_out, model_reg);
    endtask

    int          g;
    int          r;
    logic        ptr_m;
    logic        ack_prev;
    logic        gf;
    logic        gd;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        func_valid = 1'b0;
        func_data  = '0;
        dbg_req    = 1'b0;
        dbg_cmd    = 2'b00;
        dbg_wdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Reset state of every output.
        check_val("rst_ack", 32'(dbg_ack), 32'd0);
        check_val("rst_rdata", dbg_rdata, 32'd0);
        check_val("rst_err", 32'(dbg_err), 32'd0);
        check_val("rst_data_out", data_out, 32'd0);
        check_val("rst_lock", 32'(lock_state), 32'd0);
        check_val("rst_func_ready", 32'(func_ready), 32'd0);

        // Locked read, then write / unlock / read.
        dbg_txn(CMD_READ, 32'd0, g);
        func_write(32'hDEAD_BEEF);
        dbg_txn(CMD_UNLOCK, KEY, g);
        dbg_txn(CMD_READ, 32'd0, g);

        // Unlock while unlocked, reserved command, relock.
        dbg_txn(CMD_UNLOCK, 32'h1111_2222, g);
        dbg_txn(CMD_RSVD, 32'd0, g);
        dbg_txn(CMD_RELOCK, 32'd0, g);

        // Two bad keys then a good one: fail count must clear.
        dbg_txn(CMD_UNLOCK, 32'd0, g);
        dbg_txn(CMD_UNLOCK, 32'd0, g);
        dbg_txn(CMD_UNLOCK, KEY, g);
        dbg_txn(CMD_RELOCK, 32'd0, g);

        // Three bad keys -> lockout; commands in lockout fail.
        dbg_txn(CMD_UNLOCK, 32'd0, g);
        dbg_txn(CMD_UNLOCK, 32'd0, g);
        dbg_txn(CMD_UNLOCK, 32'd0, g);
        dbg_txn(CMD_UNLOCK, KEY, r);
        dbg_txn(CMD_RELOCK, 32'd0, r);
        dbg_txn(CMD_READ, 32'd0, r);
        wait_until(g + 4096);
        check_val("lockout_last", 32'(lock_state), 32'(LS_LOCKOUT));
        wait_until(g + 4097);
        model_state = LS_LOCKED;
        check_val("lockout_end", 32'(lock_state), 32'(LS_LOCKED));

        // Idle session expiry.
        dbg_txn(CMD_UNLOCK, KEY, g);
        wait_until(g + 1024);
        check_val("session_last", 32'(lock_state), 32'(LS_UNLOCKED));
        wait_until(g + 1025);
        model_state = LS_LOCKED;
        check_val("session_end", 32'(lock_state), 32'(LS_LOCKED));

        // Read on the final session cycle extends the session.
        func_write(32'h0BAD_F00D);
        dbg_txn(CMD_UNLOCK, KEY, g);
        wait_until(g + 1024);
        dbg_txn(CMD_READ, 32'd0, r);
        check_val("session_ext", 32'(lock_state), 32'(LS_UNLOCKED));
        wait_until(r + 1024);
        check_val("ext_last", 32'(lock_state), 32'(LS_UNLOCKED));
        wait_until(r + 1025);
        model_state = LS_LOCKED;
        check_val("ext_end", 32'(lock_state), 32'(LS_LOCKED));

        // Contended traffic: functional writes vs held debug READs.
        dbg_txn(CMD_UNLOCK, KEY, g);
        ptr_m      = 1'b0;
        ack_prev   = 1'b0;
        dbg_req    = 1'b1;
        dbg_cmd    = CMD_READ;
        func_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            func_data = $urandom;
            gf = 1'b0;
            gd = 1'b0;
            if (!ack_prev) begin
                if (ptr_m) gd = 1'b1;
                else       gf = 1'b1;
                ptr_m = ~ptr_m;
            end else begin
                gf = 1'b1;
            end
            @(negedge clk);
            check_val("func_ready_arb", 32'(func_ready), 32'(gf));
            if (gd) begin
                exp_t e;
                e.rdata = model_reg;
                e.err   = 1'b0;
                exp_q.push_back(e);
            end
            if (gf) model_reg = func_data;
            ack_prev = gd;
            step();
            check_val("data_out_arb", data_out, model_reg);
        end
        dbg_req    = 1'b0;
        func_valid = 1'b0;
        step();
        step();

        // Reset during an UNLOCK grant drops the ack and clears state.
        func_write(32'h1234_5678);
        check_val("pre_rst_lock", 32'(lock_state), 32'(LS_UNLOCKED));
        dbg_req   = 1'b1;
        dbg_cmd   = CMD_UNLOCK;
        dbg_wdata = KEY;
        @(negedge clk);
        rst     = 1'b1;
        dbg_req = 1'b0;
        step();
        check_val("rst_mid_ack", 32'(dbg_ack), 32'd0);
        check_val("rst_mid_lock", 32'(lock_state), 32'(LS_LOCKED));
        check_val("rst_mid_data", data_out, 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        model_state = LS_LOCKED;
        model_fail  = 0;
        model_reg   = '0;
        step();
        check_val("post_rst_ack", 32'(dbg_ack), 32'd0);
        dbg_txn(CMD_READ, 32'd0, g);

        repeat (3) step();
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_access_ctrl.md
Name: debug_access_ctrl

Overview:
Access controller for the shared 32-bit data register used by the functional datapath and exposed on the debug port. It arbitrates between the functional writer and debug requests. It gates every debug read behind a key-based unlock state machine with a failed-attempt lockout and a session timeout. Locked reads never reveal register contents.

Parameters:
DW, 32, data width of the shared register and both ports
UNLOCK_KEY, 32'hA5C3_0F1E, key value that opens a debug session
MAX_FAIL, 3, consecutive wrong keys before entering LOCKOUT
SESSION_CYCLES, 1024, idle cycles before an open session relocks automatically
LOCKOUT_CYCLES, 4096, cycles spent in LOCKOUT before returning to LOCKED
TW, 16, width of the shared session/lockout timer (must hold the larger cycle count)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
func_valid  in  1  functional write request
func_data  in  DW  functional write data
func_ready  out  1  functional write accepted this cycle (valid & ready = write)
dbg_req  in  1  debug command request; held until dbg_ack
dbg_cmd  in  2  00 = READ, 01 = UNLOCK, 10 = RELOCK, 11 = reserved
dbg_wdata  in  DW  key value for UNLOCK
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DW  read data; valid only in the dbg_ack cycle
dbg_err  out  1  error flag, qualified by dbg_ack
data_out  out  DW  current shared register value (functional consumers)
lock_state  out  2  00 = LOCKED, 01 = UNLOCKED, 10 = LOCKOUT

Behaviour:
- Reset values:
  - All outputs 0.
  - Shared register 0, state LOCKED, fail counter 0, timer 0, arbitration pointer = functional.
- Arbitration (shared register port):
  - Requesters are a functional write and a debug command.
  - When only one requests, it is granted.
  - When both request, the round-robin pointer decides. The pointer flips to the other side after each contended grant.
  - func_ready = func_valid & granted. It is combinational from the current cycle's grant.
  - At most one debug command is granted at a time. After a debug grant, no new debug grant occurs until dbg_ack has pulsed and dbg_req has been sampled again.
- Debug command latency:
  - Grant in cycle N; dbg_ack, dbg_rdata and dbg_err are registered and appear in cycle N+1.
  - dbg_rdata is 0 whenever dbg_ack = 0.
- READ:
  - If UNLOCKED: dbg_rdata = register value at grant cycle N, dbg_err = 0, session timer reloads.
  - If LOCKED or LOCKOUT: dbg_rdata = 0, dbg_err = 1.
- UNLOCK:
  - LOCKED with dbg_wdata == UNLOCK_KEY:
    - Go to UNLOCKED.
    - Fail counter cleared; timer loaded with SESSION_CYCLES-1.
    - dbg_err = 0.
  - LOCKED with a wrong key:
    - Fail counter increments; dbg_err = 1.
    - If the counter reaches MAX_FAIL: go to LOCKOUT, timer loaded with LOCKOUT_CYCLES-1, counter cleared.
  - UNLOCK while UNLOCKED: success, session timer reloads.
  - UNLOCK while LOCKOUT: dbg_err = 1, no counting (key not compared).
- RELOCK:
  - Any state except LOCKOUT goes to LOCKED, dbg_err = 0.
  - RELOCK in LOCKOUT: dbg_err = 1, state unchanged.
- Reserved command: dbg_err = 1, no state change.
- Timer behaviour:
  - UNLOCKED: the timer decrements every cycle without a debug grant. At 0 the state goes to LOCKED on the next edge.
  - LOCKOUT: the timer decrements every cycle. At 0 the state goes to LOCKED.
  - The timer never wraps; it saturates at 0.
- Functional writes:
  - data_out updates on the edge after func_valid & func_ready.
  - Writes are accepted in all lock states. Locking never blocks the functional path.
- Simultaneous events:
  - Session expiry in the same cycle as a debug READ grant: the grant wins. The read sees UNLOCKED and the timer reloads.
  - A functional write and a debug READ are never granted in the same cycle.
- Reset mid-transaction:
  - A pending dbg_ack is dropped.
  - State returns to LOCKED and the register clears.

Decomposition:
- Shared package holds:
  - lock_state encoding
  - dbg_cmd encodings (CMD_READ, CMD_UNLOCK, CMD_RELOCK)
  - default UNLOCK_KEY constant
- One natural sub-module: dac_rr_arbiter. It is a 2-requester round-robin arbiter with grant vector and pointer register.
- The lock FSM, timer and fail counter stay in the top level.

Test Plan:
- Post-reset READ, no unlock -> dbg_ack one cycle after grant, dbg_rdata = 0, dbg_err = 1, lock_state = 00.
- Func write 32'hDEAD_BEEF, then UNLOCK with 32'hA5C3_0F1E, then READ -> lock_state = 01, dbg_rdata = 32'hDEAD_BEEF, dbg_err = 0.
- Three UNLOCKs with 32'h0 -> dbg_err = 1 each; lock_state = 10 after the third. Correct key during LOCKOUT -> dbg_err = 1. After 4096 cycles -> lock_state = 00.
- Unlock, then idle 1024 cycles -> lock_state returns to 00. READ at cycle 1023 instead -> succeeds and the session extends.
- func_valid held high with continuous READ requests while unlocked -> grants alternate; func_ready low exactly in the debug-grant cycles; READ returns the value before that cycle's pending write.
- rst asserted the cycle after an UNLOCK grant -> no dbg_ack, lock_state = 00, data_out = 0.
